// File: rtl/seg_scan_4digit.sv
// Four-digit time-multiplexed seven-segment scan driver with per-slot ghost blanking,
// leading-zero suppression, per-digit decimal points and a once-per-frame input snapshot.
module seg_scan_4digit #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned SCAN_HZ        = 1000,
  parameter int unsigned BLANK_CYC      = 2000,
  parameter int unsigned LZ_BLANK       = 1,
  parameter int unsigned SEG_ACTIVE_LOW = 1,
  parameter int unsigned SEL_ACTIVE_LOW = 1
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic [3:0] unit,
  input  logic [3:0] ten,
  input  logic [3:0] hun,
  input  logic [3:0] tho,
  input  logic [3:0] dp_en,
  input  logic       disp_en,
  output logic [3:0] sel,
  output logic [7:0] seg
);

  localparam int unsigned DIV   = CLK_FREQ / SCAN_HZ;
  localparam int          CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  // Inactive output levels; XOR-ing an active-high pattern with these applies polarity.
  localparam logic [3:0] SEL_OFF = (SEL_ACTIVE_LOW != 0) ? 4'hF : 4'h0;
  localparam logic [7:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

  typedef enum logic {
    SLOT_BLANK = 1'b0,
    SLOT_DRIVE = 1'b1
  } slot_state_e;

  logic [CNT_W-1:0] cnt;
  logic [1:0]       idx;
  slot_state_e      state_q;
  slot_state_e      state_d;

  logic [3:0][3:0]  digits_sh;
  logic [3:0]       dp_sh;

  logic [3:0]       lz_mask;
  logic [3:0]       digit;
  logic [7:0]       glyph;
  logic [3:0]       sel_d;
  logic [7:0]       seg_d;

  function automatic logic [6:0] decode7(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'h3F;
      4'h1:    g = 7'h06;
      4'h2:    g = 7'h5B;
      4'h3:    g = 7'h4F;
      4'h4:    g = 7'h66;
      4'h5:    g = 7'h6D;
      4'h6:    g = 7'h7D;
      4'h7:    g = 7'h07;
      4'h8:    g = 7'h7F;
      4'h9:    g = 7'h6F;
      4'hA:    g = 7'h77;
      4'hB:    g = 7'h7C;
      4'hC:    g = 7'h39;
      4'hD:    g = 7'h5E;
      4'hE:    g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Slot counter and digit index.
  always_ff @(posedge sys_clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (sys_rst) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= SLOT_BLANK;
    else         state_q <= state_d;
  end

  // state_q tracks cnt in the same cycle: DRIVE exactly when cnt >= BLANK_CYC.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    case (state_q)
      SLOT_BLANK: if (cnt == BLANK_LAST) state_d = SLOT_DRIVE;
      SLOT_DRIVE: if (cnt == CNT_LAST)   state_d = SLOT_BLANK;
      default:                           state_d = SLOT_BLANK;
    endcase
  end

  // Frame snapshot: one coherent set of digits for all four slots.
  always_ff @(posedge sys_clk) begin
    // NOTE: the shadow registers are small and must read as zero after reset, so they are reset.
    if (sys_rst) begin
      digits_sh <= '0;
      dp_sh     <= '0;
    end else if (idx == 2'd0 && cnt == '0) begin
      digits_sh <= {tho, hun, ten, unit};
      dp_sh     <= dp_en;
    end
  end

  assign lz_mask = (LZ_BLANK != 0)
                 ? {(digits_sh[3] == 4'd0),
                    (digits_sh[3] == 4'd0) && (digits_sh[2] == 4'd0),
                    (digits_sh[3] == 4'd0) && (digits_sh[2] == 4'd0) && (digits_sh[1] == 4'd0),
                    1'b0}
                 : 4'b0000;

  always_comb begin
    digit = digits_sh[idx];
    glyph = {dp_sh[idx], decode7(digit)};
    if (lz_mask[idx]) glyph = 8'h00;
    sel_d = 4'b0000;
    seg_d = 8'h00;
    if (disp_en && state_q == SLOT_DRIVE) begin
      sel_d = 4'b0001 << idx;
      seg_d = glyph;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      sel <= SEL_OFF;
      seg <= SEG_OFF;
    end else begin
      sel <= sel_d ^ SEL_OFF;
      seg <= seg_d ^ SEG_OFF;
    end
  end

endmodule
